// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
//
// Multi-read-port register file with a per-register scoreboard, used by the
// decode stage. At issue, decode marks a destination busy. At writeback, the
// data is written and the busy bit is cleared. Each read port reports whether
// its operand is still pending, so hazard logic can stall.
//
// Optional feature (compile-time macro RF_BYPASS_EN):
//   defined   - a writeback in the current cycle is forwarded to any read
//               port that reads the same address. It also releases that
//               port's busy flag in the same cycle.
//   undefined - reads always come from the stored state. A newly written
//               value becomes visible from the next cycle.
//
// Parameters:
//   W        data width in bits
//   N        address width; 2**N registers
//   R        number of read ports
//   ZERO_R0  1: register 0 reads as 0, ignores writes and is never busy
//
// Ports:
//   clk_i         rising-edge clock
//   rst_i         synchronous reset, active-high; overrides every other input
//   regWrite_i    writeback enable
//   WA_i          writeback address
//   WD_i          writeback data
//   iss_valid_i   issue strobe: mark iss_dst_i busy
//   iss_dst_i     destination register of the issuing instruction
//   clr_busy_i    flush: clear all busy bits
//   rd_addr_i     read addresses, port i = rd_addr_i[i*N +: N]
//   rd_data_o     read data, port i = rd_data_o[i*W +: W]
//   rd_busy_o     per-port "operand pending" flag
//   busy_o        raw scoreboard vector
//   busy_cnt_o    registered count of set busy bits (0 .. 2**N)
// ---------------------------------------------------------------------------
module reg_file_sb #(
  parameter int W       = 16,
  parameter int N       = 3,
  parameter int R       = 2,
  parameter int ZERO_R0 = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             regWrite_i,
  input  logic [N-1:0]     WA_i,
  input  logic [W-1:0]     WD_i,
  input  logic             iss_valid_i,
  input  logic [N-1:0]     iss_dst_i,
  input  logic             clr_busy_i,
  input  logic [R*N-1:0]   rd_addr_i,
  output logic [R*W-1:0]   rd_data_o,
  output logic [R-1:0]     rd_busy_o,
  output logic [2**N-1:0]  busy_o,
  output logic [N:0]       busy_cnt_o
);

  localparam int NREG = 2 ** N;

  logic [W-1:0]    regs_q [NREG];
  logic [W-1:0]    regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [N:0]      busyCnt_q;
  logic [N:0]      busyCnt_d;

  logic wrEn;
  logic issEn;

  // With ZERO_R0, anything aimed at register 0 is dropped before it can
  // touch either the data array or the scoreboard.
  assign wrEn  = regWrite_i  && !((ZERO_R0 != 0) && (WA_i == '0));
  assign issEn = iss_valid_i && !((ZERO_R0 != 0) && (iss_dst_i == '0));

  // Next-state for data and scoreboard. The order of the busy updates
  // encodes the priority: flush beats issue, and issue beats the writeback
  // clear. When a write and an issue hit the same register, the data is
  // still written, but the register stays busy for the newer producer.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wrEn) begin
      regs_d[WA_i] = WD_i;
      busy_d[WA_i] = 1'b0;
    end
    if (issEn) begin
      busy_d[iss_dst_i] = 1'b1;
    end
    if (clr_busy_i) begin
      busy_d = '0;
    end
  end

  // The count is computed from the next busy vector. The registered count
  // therefore always matches the registered busy vector.
  always_comb begin
    busyCnt_d = '0;
    for (int k = 0; k < NREG; k++) begin
      busyCnt_d = busyCnt_d + {{N{1'b0}}, busy_d[k]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NREG; k++) begin
        regs_q[k] <= '0;
      end
      busy_q    <= '0;
      busyCnt_q <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        regs_q[k] <= regs_d[k];
      end
      busy_q    <= busy_d;
      busyCnt_q <= busyCnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = busyCnt_q;

  // Read ports are independent combinational muxes. Any number of ports
  // may select the same address.
  for (genvar g = 0; g < R; g++) begin : gRead
    logic [N-1:0] addr;
    logic [W-1:0] stored;

    assign addr   = rd_addr_i[g*N +: N];
    assign stored = ((ZERO_R0 != 0) && (addr == '0)) ? '0 : regs_q[addr];

`ifdef RF_BYPASS_EN
    // wrEn already excludes register 0 under ZERO_R0, so a hit never
    // forwards into a hard-wired zero register.
    logic hit;
    assign hit                  = wrEn && (WA_i == addr);
    assign rd_data_o[g*W +: W]  = hit ? WD_i : stored;
    assign rd_busy_o[g]         = busy_q[addr] & ~hit;
`else
    assign rd_data_o[g*W +: W]  = stored;
    assign rd_busy_o[g]         = busy_q[addr];
`endif
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_sb
//
// Directed bench for reg_file_sb (W=16, N=3, R=2). It uses two instances:
//   dut  - ZERO_R0=0
//   dutZ - ZERO_R0=1
// Both instances share the same stimulus. Expected values are written by
// hand. Where a value depends on RF_BYPASS_EN, both values are listed.
// ---------------------------------------------------------------------------
module tb_reg_file_sb;

  localparam int W = 16;
  localparam int N = 3;
  localparam int R = 2;

  logic             clk;
  logic             rst;
  logic             regWrite;
  logic [N-1:0]     wa;
  logic [W-1:0]     wd;
  logic             issValid;
  logic [N-1:0]     issDst;
  logic             clrBusy;
  logic [R*N-1:0]   rdAddr;

  logic [R*W-1:0]   rdData,  rdDataZ;
  logic [R-1:0]     rdBusy,  rdBusyZ;
  logic [2**N-1:0]  busy,    busyZ;
  logic [N:0]       busyCnt, busyCntZ;

  int assertCount = 0;
  int failCount   = 0;

  reg_file_sb #(.W(W), .N(N), .R(R), .ZERO_R0(0)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .regWrite_i  (regWrite),
    .WA_i        (wa),
    .WD_i        (wd),
    .iss_valid_i (issValid),
    .iss_dst_i   (issDst),
    .clr_busy_i  (clrBusy),
    .rd_addr_i   (rdAddr),
    .rd_data_o   (rdData),
    .rd_busy_o   (rdBusy),
    .busy_o      (busy),
    .busy_cnt_o  (busyCnt)
  );

  reg_file_sb #(.W(W), .N(N), .R(R), .ZERO_R0(1)) dutZ (
    .clk_i       (clk),
    .rst_i       (rst),
    .regWrite_i  (regWrite),
    .WA_i        (wa),
    .WD_i        (wd),
    .iss_valid_i (issValid),
    .iss_dst_i   (issDst),
    .clr_busy_i  (clrBusy),
    .rd_addr_i   (rdAddr),
    .rd_data_o   (rdDataZ),
    .rd_busy_o   (rdBusyZ),
    .busy_o      (busyZ),
    .busy_cnt_o  (busyCntZ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single point of comparison: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's worth of inputs. Read port 0 uses a0 and port 1 uses a1.
  task automatic applyStimulus(input logic wr, input logic [N-1:0] a,
                               input logic [W-1:0] d, input logic iv,
                               input logic [N-1:0] dst, input logic clr,
                               input logic [N-1:0] a0, input logic [N-1:0] a1);
    regWrite = wr;
    wa       = a;
    wd       = d;
    issValid = iv;
    issDst   = dst;
    clrBusy  = clr;
    rdAddr   = {a1, a0};
  endtask

  // Advance one active edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] expSame;
    logic         expBusySame;

    rst = 1'b1;
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd7);
    step();
    rst = 1'b0;
    #1;

    // Reset state
    checkOutput("reset_rd0",   {16'h0, rdData[15:0]},  32'h0);
    checkOutput("reset_rd1",   {16'h0, rdData[31:16]}, 32'h0);
    checkOutput("reset_busy",  {24'h0, busy},          32'h00);
    checkOutput("reset_cnt",   {28'h0, busyCnt},       32'h0);

    // Write/read, with both ports reading address 5
    applyStimulus(1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0, 1'b0, 3'd5, 3'd5);
    #1;
`ifdef RF_BYPASS_EN
    expSame = 16'hBEEF;
`else
    expSame = 16'h0000;
`endif
    checkOutput("wr_same_cycle_p0", {16'h0, rdData[15:0]},  {16'h0, expSame});
    checkOutput("wr_same_cycle_p1", {16'h0, rdData[31:16]}, {16'h0, expSame});
    step();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd5, 3'd5);
    #1;
    checkOutput("wr_next_p0", {16'h0, rdData[15:0]},  32'hBEEF);
    checkOutput("wr_next_p1", {16'h0, rdData[31:16]}, 32'hBEEF);

    // Scoreboard: issue to 3, then write back to 3
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 1'b0, 3'd3, 3'd5);
    step();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd3, 3'd5);
    #1;
    checkOutput("iss_busy",   {24'h0, busy},         32'h08);
    checkOutput("iss_cnt",    {28'h0, busyCnt},      32'h1);
    checkOutput("iss_rdbusy", {31'h0, rdBusy[0]},    32'h1);
    checkOutput("iss_rdbusy_other", {31'h0, rdBusy[1]}, 32'h0);
    applyStimulus(1'b1, 3'd3, 16'h0033, 1'b0, 3'd0, 1'b0, 3'd3, 3'd5);
    #1;
`ifdef RF_BYPASS_EN
    expBusySame = 1'b0;
`else
    expBusySame = 1'b1;
`endif
    checkOutput("wb_rdbusy_same_cycle", {31'h0, rdBusy[0]}, {31'h0, expBusySame});
    step();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd3, 3'd5);
    #1;
    checkOutput("wb_busy",   {24'h0, busy},         32'h00);
    checkOutput("wb_cnt",    {28'h0, busyCnt},      32'h0);
    checkOutput("wb_rdbusy", {31'h0, rdBusy[0]},    32'h0);
    checkOutput("wb_data",   {16'h0, rdData[15:0]}, 32'h0033);

    // Collision: write and issue to register 2 on the same edge
    applyStimulus(1'b1, 3'd2, 16'h1234, 1'b1, 3'd2, 1'b0, 3'd0, 3'd2);
    step();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd2);
    #1;
    checkOutput("coll_data",   {16'h0, rdData[31:16]}, 32'h1234);
    checkOutput("coll_busy",   {24'h0, busy},          32'h04);
    checkOutput("coll_rdbusy", {31'h0, rdBusy[1]},     32'h1);
    checkOutput("coll_cnt",    {28'h0, busyCnt},       32'h1);

    // Flush: build busy=FE, then flush together with an issue and a write
    for (int i = 1; i < 8; i++) begin
      applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 1'b0, 3'd1, 3'd2);
      step();
    end
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd1, 3'd2);
    #1;
    checkOutput("pre_flush_busy", {24'h0, busy},    32'hFE);
    checkOutput("pre_flush_cnt",  {28'h0, busyCnt}, 32'h7);
    applyStimulus(1'b1, 3'd1, 16'h0007, 1'b1, 3'd4, 1'b1, 3'd1, 3'd4);
    step();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd1, 3'd4);
    #1;
    checkOutput("flush_busy",   {24'h0, busy},         32'h00);
    checkOutput("flush_cnt",    {28'h0, busyCnt},      32'h0);
    checkOutput("flush_data",   {16'h0, rdData[15:0]}, 32'h0007);
    checkOutput("flush_rdbusy", {31'h0, rdBusy[1]},    32'h0);

    // Full scoreboard: all 8 busy, so the count reaches its maximum
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 1'b0, 3'd0, 3'd7);
      step();
    end
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd7);
    #1;
    checkOutput("full_busy", {24'h0, busy},    32'hFF);
    checkOutput("full_cnt",  {28'h0, busyCnt}, 32'h8);

    // Mid-operation reset overrides a simultaneous write and issue
    rst = 1'b1;
    applyStimulus(1'b1, 3'd5, 16'hAAAA, 1'b1, 3'd5, 1'b0, 3'd5, 3'd1);
    step();
    rst = 1'b0;
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd5, 3'd1);
    #1;
    checkOutput("rst_mid_busy", {24'h0, busy},          32'h00);
    checkOutput("rst_mid_cnt",  {28'h0, busyCnt},       32'h0);
    checkOutput("rst_mid_rd5",  {16'h0, rdData[15:0]},  32'h0);
    checkOutput("rst_mid_rd1",  {16'h0, rdData[31:16]}, 32'h0);

    // Register 0: hard-wired zero in dutZ, ordinary register in dut
    applyStimulus(1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 1'b0, 3'd0, 3'd0);
    #1;
    checkOutput("z_same_cycle", {16'h0, rdDataZ[15:0]}, 32'h0);
    step();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
    #1;
    checkOutput("z_rd0",     {16'h0, rdDataZ[15:0]}, 32'h0);
    checkOutput("z_busy",    {24'h0, busyZ},         32'h00);
    checkOutput("z_cnt",     {28'h0, busyCntZ},      32'h0);
    checkOutput("z_rdbusy",  {31'h0, rdBusyZ[0]},    32'h0);
    checkOutput("nz_rd0",    {16'h0, rdData[15:0]},  32'hFFFF);
    checkOutput("nz_busy",   {24'h0, busy},          32'h01);
    checkOutput("nz_cnt",    {28'h0, busyCnt},       32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
